// File: rtl/key_time_entry.sv
// rtl/key_time_entry.sv - PS/2 keyboard entry of HH:MM:SS time and alarm values (optional idle timeout: KEY_ENTRY_TIMEOUT_EN)
module key_time_entry #(
  parameter int unsigned TIMEOUT_CYC = 500000000
) (
  input  logic       CLK_50,
  input  logic       clrn,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  output logic       kb_nextdata_n,
  output logic       set_en,
  output logic       alarm_en,
  output logic       time_valid,
  output logic       alarm_valid,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [2:0] digit_cnt,
  output logic       entry_err
);

  typedef enum logic [1:0] {POP_IDLE, POP_LOW, POP_GAP} pop_t;
  typedef enum logic [1:0] {M_IDLE, M_TIME, M_ALARM} mode_t;
  typedef enum logic [2:0] {K_NONE, K_DIGIT, K_T, K_A, K_ENTER, K_BKSP, K_ESC} key_t;

  pop_t            pop_state, pop_nxt;
  mode_t           mode, mode_nxt;
  logic            accept;
  logic            brk_flag;
  key_t            key_code, key_evt;
  logic [3:0]      key_digit;
  logic [5:0][3:0] dig_buf, buf_nxt;
  logic [2:0]      cnt_nxt;
  logic [7:0]      hour_nxt, min_nxt, sec_nxt;
  logic            tv_nxt, av_nxt, err_nxt;
  logic            entry_ok;
  logic            timeout_hit;

  // Pop sequencer state register
  always_ff @(posedge CLK_50) begin
    if (!clrn) pop_state <= POP_IDLE;
    else       pop_state <= pop_nxt;
  end

  // Accept a byte when idle, then one low cycle and one gap cycle before the next
  always_comb begin
    pop_nxt = pop_state;
    accept  = 1'b0;
    case (pop_state)
      POP_IDLE: if (kb_ready) begin
        accept  = 1'b1;
        pop_nxt = POP_LOW;
      end
      POP_LOW: pop_nxt = POP_GAP;
      POP_GAP: pop_nxt = POP_IDLE;
      default: pop_nxt = POP_IDLE;
    endcase
  end

  // FIFO pop strobe: low exactly on the cycle after an accept
  always_ff @(posedge CLK_50) begin
    if (!clrn) kb_nextdata_n <= 1'b1;
    else       kb_nextdata_n <= !accept;
  end

  // Break prefix tracking: the byte after 0xF0 is a release and is swallowed
  always_ff @(posedge CLK_50) begin
    if (!clrn) begin
      brk_flag <= 1'b0;
    end else if (accept) begin
      if (brk_flag)              brk_flag <= 1'b0;
      else if (kb_data == 8'hF0) brk_flag <= 1'b1;
    end
  end

  // Scan set 2 make-code decode; prefixes and unknown codes fall to K_NONE
  always_comb begin
    key_code  = K_NONE;
    key_digit = 4'd0;
    case (kb_data)
      8'h45: begin key_code = K_DIGIT; key_digit = 4'd0; end
      8'h16: begin key_code = K_DIGIT; key_digit = 4'd1; end
      8'h1E: begin key_code = K_DIGIT; key_digit = 4'd2; end
      8'h26: begin key_code = K_DIGIT; key_digit = 4'd3; end
      8'h25: begin key_code = K_DIGIT; key_digit = 4'd4; end
      8'h2E: begin key_code = K_DIGIT; key_digit = 4'd5; end
      8'h36: begin key_code = K_DIGIT; key_digit = 4'd6; end
      8'h3D: begin key_code = K_DIGIT; key_digit = 4'd7; end
      8'h3E: begin key_code = K_DIGIT; key_digit = 4'd8; end
      8'h46: begin key_code = K_DIGIT; key_digit = 4'd9; end
      8'h2C: key_code = K_T;
      8'h1C: key_code = K_A;
      8'h5A: key_code = K_ENTER;
      8'h66: key_code = K_BKSP;
      8'h76: key_code = K_ESC;
      default: key_code = K_NONE;
    endcase
  end

  assign key_evt = (accept && !brk_flag) ? key_code : K_NONE;

  // Range check of the buffered digits; positions are HH MM SS, tens first
  assign entry_ok = (digit_cnt == 3'd6) &&
                    ((dig_buf[0] < 4'd2) || ((dig_buf[0] == 4'd2) && (dig_buf[1] <= 4'd3))) &&
                    (dig_buf[2] <= 4'd5) && (dig_buf[4] <= 4'd5);

`ifdef KEY_ENTRY_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_cnt;

  // Idle counter: restarts on any decoded key and while no entry is open
  always_ff @(posedge CLK_50) begin
    if (!clrn)                                   to_cnt <= '0;
    else if (mode == M_IDLE || key_evt != K_NONE) to_cnt <= '0;
    else if (to_cnt != TO_LAST)                  to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (mode != M_IDLE) && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Mode FSM and entry datapath register
  always_ff @(posedge CLK_50) begin
    if (!clrn) begin
      mode        <= M_IDLE;
      dig_buf     <= '0;
      digit_cnt   <= 3'd0;
      hour_bcd    <= 8'h00;
      min_bcd     <= 8'h00;
      sec_bcd     <= 8'h00;
      time_valid  <= 1'b0;
      alarm_valid <= 1'b0;
      entry_err   <= 1'b0;
    end else begin
      mode        <= mode_nxt;
      dig_buf     <= buf_nxt;
      digit_cnt   <= cnt_nxt;
      hour_bcd    <= hour_nxt;
      min_bcd     <= min_nxt;
      sec_bcd     <= sec_nxt;
      time_valid  <= tv_nxt;
      alarm_valid <= av_nxt;
      entry_err   <= err_nxt;
    end
  end

  // Next mode, buffer and pulses; a decoded key always wins over the timeout
  always_comb begin
    mode_nxt = mode;
    buf_nxt  = dig_buf;
    cnt_nxt  = digit_cnt;
    hour_nxt = hour_bcd;
    min_nxt  = min_bcd;
    sec_nxt  = sec_bcd;
    tv_nxt   = 1'b0;
    av_nxt   = 1'b0;
    err_nxt  = 1'b0;
    case (key_evt)
      K_T: begin
        mode_nxt = M_TIME;
        buf_nxt  = '0;
        cnt_nxt  = 3'd0;
      end
      K_A: begin
        mode_nxt = M_ALARM;
        buf_nxt  = '0;
        cnt_nxt  = 3'd0;
      end
      K_DIGIT: begin
        if (mode != M_IDLE && digit_cnt < 3'd6) begin
          buf_nxt[digit_cnt] = key_digit;
          cnt_nxt            = digit_cnt + 3'd1;
        end
      end
      K_BKSP: begin
        if (mode != M_IDLE && digit_cnt != 3'd0) cnt_nxt = digit_cnt - 3'd1;
      end
      K_ESC: begin
        if (mode != M_IDLE) begin
          mode_nxt = M_IDLE;
          buf_nxt  = '0;
          cnt_nxt  = 3'd0;
        end
      end
      K_ENTER: begin
        if (mode != M_IDLE) begin
          buf_nxt = '0;
          cnt_nxt = 3'd0;
          if (entry_ok) begin
            hour_nxt = {dig_buf[0], dig_buf[1]};
            min_nxt  = {dig_buf[2], dig_buf[3]};
            sec_nxt  = {dig_buf[4], dig_buf[5]};
            tv_nxt   = (mode == M_TIME);
            av_nxt   = (mode == M_ALARM);
            mode_nxt = M_IDLE;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (timeout_hit) begin
          mode_nxt = M_IDLE;
          buf_nxt  = '0;
          cnt_nxt  = 3'd0;
          err_nxt  = 1'b1;
        end
      end
    endcase
  end

  assign set_en   = (mode == M_TIME);
  assign alarm_en = (mode == M_ALARM);

endmodule

// File: tb/tb_key_time_entry.sv
// tb/tb_key_time_entry.sv - scoreboard bench for key_time_entry
module tb_key_time_entry;

  localparam logic [7:0] KT = 8'h2C, KA = 8'h1C, KENT = 8'h5A, KBS = 8'h66, KESC = 8'h76;

  typedef struct {
    int         kind;
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
  } exp_t;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_nextdata_n;
  logic       set_en, alarm_en, time_valid, alarm_valid, entry_err;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [2:0] digit_cnt;

  logic [7:0] fifo[$];
  exp_t       sb[$];
  logic [7:0] dcode [10];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_low = -100;
  int pop_lows = 0;

  key_time_entry #(.TIMEOUT_CYC(100)) dut (
    .CLK_50(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_nextdata_n(kb_nextdata_n), .set_en(set_en), .alarm_en(alarm_en),
    .time_valid(time_valid), .alarm_valid(alarm_valid), .hour_bcd(hour_bcd),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .digit_cnt(digit_cnt), .entry_err(entry_err)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Keyboard FIFO model: a byte leaves when the pop strobe is seen low at an edge
  always @(posedge clk) begin
    cyc++;
    if (kb_nextdata_n === 1'b0 && fifo.size() != 0) void'(fifo.pop_front());
  end

  // Pulse scoreboard and pop strobe spacing monitor
  always @(negedge clk) begin
    int kind_obs;
    exp_t e;
    if (kb_nextdata_n === 1'b0) begin
      pop_lows++;
      check("pop_gap", ((cyc - last_low) >= 3) ? 1 : 0, 1);
      last_low = cyc;
    end
    if (time_valid === 1'b1 || alarm_valid === 1'b1 || entry_err === 1'b1) begin
      kind_obs = time_valid ? 0 : (alarm_valid ? 1 : 2);
      check("pulse_excl", 32'(time_valid) + 32'(alarm_valid) + 32'(entry_err), 1);
      if (sb.size() == 0) begin
        check("unexpected_pulse_kind", kind_obs, 99);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", kind_obs, e.kind);
        if (e.kind != 2) begin
          check("pulse_hour", hour_bcd, e.h);
          check("pulse_min", min_bcd, e.m);
          check("pulse_sec", sec_bcd, e.s);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    kb_ready = (fifo.size() != 0);
    kb_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic expect_evt(input int kind, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    exp_t e;
    e.kind = kind; e.h = h; e.m = m; e.s = s;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    tick();
    while (fifo.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("fifo_drain", fifo.size(), 0);
    repeat (3) tick();
  endtask

  task automatic send_key(input logic [7:0] code);
    fifo.push_back(code);
    fifo.push_back(8'hF0);
    fifo.push_back(code);
    drain();
  endtask

  task automatic send_digits(input int d0, input int d1, input int d2, input int d3, input int d4, input int d5);
    send_key(dcode[d0]); send_key(dcode[d1]); send_key(dcode[d2]);
    send_key(dcode[d3]); send_key(dcode[d4]); send_key(dcode[d5]);
  endtask

  initial begin
    int lows0;
    int n;
    dcode = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    repeat (3) tick();
    check("rst_nextdata_n", kb_nextdata_n, 1);
    check("rst_set_en", set_en, 0);
    check("rst_alarm_en", alarm_en, 0);
    check("rst_hms", {hour_bcd, min_bcd, sec_bcd}, 0);
    check("rst_cnt", digit_cnt, 0);
    check("rst_pulses", {time_valid, alarm_valid, entry_err}, 0);
    clrn = 1'b1;
    tick();

    // Time entry 12:34:56
    send_key(KT);
    check("t_set_en", set_en, 1);
    check("t_cnt0", digit_cnt, 0);
    send_digits(1, 2, 3, 4, 5, 6);
    check("t_cnt6", digit_cnt, 6);
    expect_evt(0, 8'h12, 8'h34, 8'h56);
    send_key(KENT);
    check("t_set_en_off", set_en, 0);
    check("t_hms", {hour_bcd, min_bcd, sec_bcd}, 32'h123456);
    check("t_cnt_clr", digit_cnt, 0);

    // Alarm 24:00:00 rejected; seventh digit dropped
    send_key(KA);
    check("a_alarm_en", alarm_en, 1);
    send_digits(2, 4, 0, 0, 0, 0);
    send_key(dcode[7]);
    check("a_cnt_sat", digit_cnt, 6);
    expect_evt(2, 0, 0, 0);
    send_key(KENT);
    check("a_err_alarm_en", alarm_en, 1);
    check("a_err_cnt", digit_cnt, 0);
    check("a_err_hms", {hour_bcd, min_bcd, sec_bcd}, 32'h123456);
    send_key(KESC);
    check("a_esc", alarm_en, 0);

    // Backspace and escape
    send_key(KT);
    send_key(dcode[1]); check("bs_cnt1", digit_cnt, 1);
    send_key(dcode[2]); check("bs_cnt2", digit_cnt, 2);
    send_key(KBS);      check("bs_cnt3", digit_cnt, 1);
    send_key(dcode[3]); check("bs_cnt4", digit_cnt, 2);
    send_key(KESC);     check("bs_cnt5", digit_cnt, 0);
    check("bs_set_en", set_en, 0);

    // Idle ignores digits
    send_key(dcode[5]);
    check("idle_digit", digit_cnt, 0);

    // Backspace at zero and E0-prefixed digit
    send_key(KT);
    send_key(KBS);
    check("bs_zero", digit_cnt, 0);
    fifo.push_back(8'hE0); fifo.push_back(8'h16);
    fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'h16);
    drain();
    check("e0_digit", digit_cnt, 1);
    send_key(KESC);

    // Boundary 23:59:59 accepted
    send_key(KT);
    send_digits(2, 3, 5, 9, 5, 9);
    expect_evt(0, 8'h23, 8'h59, 8'h59);
    send_key(KENT);
    check("max_hms", {hour_bcd, min_bcd, sec_bcd}, 32'h235959);

    // Alarm 07:30:00 accepted, then a short alarm entry rejected
    send_key(KA);
    send_digits(0, 7, 3, 0, 0, 0);
    expect_evt(1, 8'h07, 8'h30, 8'h00);
    send_key(KENT);
    check("al_alarm_en", alarm_en, 0);
    send_key(KA);
    send_key(dcode[1]); send_key(dcode[2]); send_key(dcode[3]); send_key(dcode[4]); send_key(dcode[5]);
    expect_evt(2, 0, 0, 0);
    send_key(KENT);
    check("short_hms", {hour_bcd, min_bcd, sec_bcd}, 32'h073000);
    send_key(KESC);

    // Four bytes queued back to back
    lows0 = pop_lows;
    fifo.push_back(KT); fifo.push_back(dcode[1]); fifo.push_back(dcode[2]); fifo.push_back(dcode[3]);
    drain();
    check("burst_pops", pop_lows - lows0, 4);
    check("burst_cnt", digit_cnt, 3);
    send_key(KESC);

    // Idle timeout
`ifdef KEY_ENTRY_TIMEOUT_EN
    expect_evt(2, 0, 0, 0);
`endif
    send_key(KT);
    repeat (150) tick();
`ifdef KEY_ENTRY_TIMEOUT_EN
    check("to_set_en", set_en, 0);
`else
    check("to_set_en", set_en, 1);
`endif
    send_key(KESC);

    // Reset mid-entry and mid-pop
    send_key(KT);
    send_key(dcode[1]);
    send_key(dcode[2]);
    fifo.push_back(dcode[3]);
    n = 0;
    tick();
    while (kb_nextdata_n !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    check("mid_pop_seen", kb_nextdata_n, 0);
    clrn = 1'b0;
    tick();
    check("mr_nextdata_n", kb_nextdata_n, 1);
    check("mr_modes", {set_en, alarm_en}, 0);
    check("mr_cnt", digit_cnt, 0);
    check("mr_hms", {hour_bcd, min_bcd, sec_bcd}, 0);
    check("mr_pulses", {time_valid, alarm_valid, entry_err}, 0);
    check("mr_byte_lost", fifo.size(), 0);
    clrn = 1'b1;
    repeat (10) tick();
    check("mr_idle_cnt", digit_cnt, 0);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
